// File: rtl/d_mem_pkg.sv
// Shared defaults and derived field widths for the banked data memory.
package d_mem_pkg;

    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_ADDR_W     = 32;
    localparam int DEFAULT_NUM_CHIPS  = 4;
    localparam int DEFAULT_CHIP_WORDS = 16;

    localparam int CHIP_SEL_W = $clog2(DEFAULT_NUM_CHIPS);
    localparam int WORD_IDX_W = $clog2(DEFAULT_CHIP_WORDS);

endpackage

// File: rtl/d_mem_chip.sv
// One memory bank: synchronous write and clear, combinational read.
module d_mem_chip
    import d_mem_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int CHIP_WORDS = DEFAULT_CHIP_WORDS,
    parameter int IDX_W      = $clog2(CHIP_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [CHIP_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHIP_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/d_mem_base.sv
// Banked word-addressed data memory: NUM_CHIPS banks, chip select decode,
// read mux and registered read data.
module d_mem_base
    import d_mem_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int NUM_CHIPS  = DEFAULT_NUM_CHIPS,
    parameter int CHIP_WORDS = DEFAULT_CHIP_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              readWrite,
    output logic [DATA_W-1:0] dataOut
);

    localparam int SEL_W = $clog2(NUM_CHIPS);
    localparam int IDX_W = $clog2(CHIP_WORDS);
    localparam int TOT_W = SEL_W + IDX_W;

    logic [SEL_W-1:0]  sel;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic [DATA_W-1:0] rd [NUM_CHIPS];

    assign sel = addr[IDX_W +: SEL_W];
    assign idx = addr[IDX_W-1:0];

    // Any set bit above the chip-select field means the address is past the end.
    generate
        if (ADDR_W > TOT_W) begin : g_range
            assign in_range = ~|addr[ADDR_W-1:TOT_W];
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    for (genvar c = 0; c < NUM_CHIPS; c++) begin : g_chip
        logic we;
        assign we = enable & readWrite & in_range & (sel == SEL_W'(c));

        d_mem_chip #(
            .DATA_W     (DATA_W),
            .CHIP_WORDS (CHIP_WORDS),
            .IDX_W      (IDX_W)
        ) u_chip (
            .clk   (clk),
            .reset (reset),
            .we    (we),
            .idx   (idx),
            .wdata (dataIn),
            .rdata (rd[c])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut <= '0;
        end else if (enable && !readWrite) begin
            dataOut <= in_range ? rd[sel] : '0;
        end
    end

endmodule

// File: tb/tb_d_mem_base.sv
// Randomized bench for d_mem_base against a flat-array reference model,
// plus directed sequences with literal expectations.
module tb_d_mem_base;

    localparam int TOTAL = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] dataIn = '0;
    logic        readWrite = 1'b0;
    logic [31:0] dataOut;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [TOTAL];
    logic [31:0] model_out = '0;
    bit          model_valid = 1'b0;

    d_mem_base #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .NUM_CHIPS  (4),
        .CHIP_WORDS (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .addr      (addr),
        .dataIn    (dataIn),
        .readWrite (readWrite),
        .dataOut   (dataOut)
    );

    always #5 clk = ~clk;

    // Reference model: flat word array, updated from the inputs seen at each edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < TOTAL; i++) model_mem[i] = '0;
                model_out = '0;
                model_valid = 1'b1;
            end else if (enable) begin
                if (readWrite) begin
                    if (addr < TOTAL) model_mem[addr] = dataIn;
                end else begin
                    model_out = (addr < TOTAL) ? model_mem[addr] : 32'd0;
                end
            end
            #1;
            if (model_valid) begin
                n_cmp++;
                if (dataOut !== model_out) begin
                    n_bad++;
                    $display("FAIL model_cmp t=%0t addr=%0d got=%h want=%h",
                             $time, addr, dataOut, model_out);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = r; enable = e; readWrite = w; addr = a; dataIn = d;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [31:0] want);
        n_cmp++;
        if (dataOut !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, dataOut, want);
        end
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        cyc(1, 1, 1, 32'd7, 32'd123);
        lit("reset_out", 32'd0);
        cyc(0, 1, 0, 32'd7, 32'd0);
        lit("reset_read7", 32'd0);

        cyc(0, 1, 1, 32'd7, 32'd20);
        lit("write_holds_out", 32'd0);
        cyc(0, 1, 0, 32'd7, 32'd0);
        lit("read7", 32'd20);

        cyc(0, 1, 1, 32'd23, 32'hDEADBEEF);
        cyc(0, 1, 1, 32'd63, 32'd5);
        cyc(0, 1, 0, 32'd7, 32'd0);
        lit("iso_read7", 32'd20);
        cyc(0, 1, 0, 32'd23, 32'd0);
        lit("iso_read23", 32'hDEADBEEF);
        cyc(0, 1, 0, 32'd63, 32'd0);
        lit("iso_read63", 32'd5);
        cyc(0, 1, 0, 32'd39, 32'd0);
        lit("iso_read39", 32'd0);

        cyc(0, 1, 0, 32'd63, 32'd0);
        cyc(0, 0, 1, 32'd7, 32'd99);
        lit("en_low_hold", 32'd5);
        cyc(0, 0, 0, 32'd23, 32'd0);
        lit("en_low_read", 32'd5);
        cyc(0, 1, 0, 32'd7, 32'd0);
        lit("en_low_after", 32'd20);

        cyc(0, 1, 1, 32'd0, 32'h1234);
        cyc(0, 1, 1, 32'd64, 32'd77);
        cyc(0, 1, 1, 32'h8000_0007, 32'd88);
        cyc(0, 1, 0, 32'd64, 32'd0);
        lit("oor_read64", 32'd0);
        cyc(0, 1, 0, 32'd0, 32'd0);
        lit("oor_read0", 32'h1234);
        cyc(0, 1, 0, 32'd7, 32'd0);
        lit("oor_read7", 32'd20);

        cyc(1, 1, 1, 32'd5, 32'd11);
        lit("rst_prio_out", 32'd0);
        cyc(0, 1, 0, 32'd5, 32'd0);
        lit("rst_prio_read5", 32'd0);
        cyc(0, 1, 0, 32'd7, 32'd0);
        lit("rst_prio_read7", 32'd0);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'd64 + $urandom_range(0, 8);
                default: a = $urandom_range(0, TOTAL - 1);
            endcase
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
                $urandom_range(0, 1), a, $urandom);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
